// File: rtl/cla_add_sequencer_if.sv
// Handshake and datapath bus bundle for the CLA adder sequencer.
// slave = sequencer side, master = producer/consumer/datapath side.
interface cla_add_sequencer_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic [N-1:0] dp_data_in;
    logic         dp_load_a;
    logic         dp_load_b;
    logic         dp_clr_a;
    logic         dp_clr_b;
    logic         dp_carry_in;
    logic [N:0]   dp_data_out;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic         err;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, dp_data_out, out_ready,
        output in_ready, dp_data_in, dp_load_a, dp_load_b, dp_clr_a, dp_clr_b,
               dp_carry_in, out_valid, out_sum, out_cout, busy, err
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, dp_data_out, out_ready,
        input  in_ready, dp_data_in, dp_load_a, dp_load_b, dp_clr_a, dp_clr_b,
               dp_carry_in, out_valid, out_sum, out_cout, busy, err
    );
endinterface

// File: rtl/cla_add_sequencer.sv
// Sequencer that loads operands into a CLA datapath, waits SETTLE cycles and captures {carry, sum}.
// Optional result self-check enabled by defining CLA_SEQ_CHECK_EN (drives sticky err).
module cla_add_sequencer #(
    parameter int N      = 16,
    parameter int SETTLE = 1
) (
    input logic               clk,
    input logic               rst_n,
    cla_add_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WAIT,
        ST_OUT
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, b_q;
    logic         cin_q;
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         out_valid_q;
    logic [3:0]   cnt_q;
    logic         capture;
    logic         accept;

    assign accept  = (state_q == ST_IDLE) && bus.in_valid;
    assign capture = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
                cin_q <= bus.in_cin;
            end
            if (state_q == ST_LOAD_B)
                cnt_q <= SETTLE_INIT;
            else if (state_q == ST_WAIT && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            if (capture) begin
                sum_q       <= bus.dp_data_out[N-1:0];
                cout_q      <= bus.dp_data_out[N];
                out_valid_q <= 1'b1;
            end else if (state_q == ST_OUT && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.in_ready   = 1'b0;
        bus.busy       = 1'b1;
        bus.dp_data_in = '0;
        bus.dp_load_a  = 1'b0;
        bus.dp_load_b  = 1'b0;
        bus.dp_clr_a   = 1'b0;
        bus.dp_clr_b   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                bus.dp_clr_a = 1'b1;
                bus.dp_clr_b = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                bus.dp_data_in = a_q;
                bus.dp_load_a  = 1'b1;
                state_d        = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                bus.dp_data_in = b_q;
                bus.dp_load_b  = 1'b1;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign bus.dp_carry_in = cin_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sum     = sum_q;
    assign bus.out_cout    = cout_q;

`ifdef CLA_SEQ_CHECK_EN
    logic [N:0] ref_sum;
    logic       err_q;

    assign ref_sum = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};

    // Sticky: only reset clears a detected datapath mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (capture && (bus.dp_data_out != ref_sum))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_cla_add_sequencer.sv
// Self-checking bench for cla_add_sequencer with a behavioural CLA datapath model and result scoreboard.
module tb_cla_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_zero = 1'b0;
    logic [15:0] ra = '0;
    logic [15:0] rb = '0;
    int errors = 0;
    int checks = 0;
    logic [16:0] sb_q[$];
`ifdef CLA_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    cla_add_sequencer_if #(.N(16)) bus ();

    cla_add_sequencer #(.N(16), .SETTLE(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Datapath model: two operand registers plus a combinational adder.
    always @(posedge clk) begin
        if (bus.dp_clr_a) ra <= '0;
        else if (bus.dp_load_a) ra <= bus.dp_data_in;
        if (bus.dp_clr_b) rb <= '0;
        else if (bus.dp_load_b) rb <= bus.dp_data_in;
    end
    assign bus.dp_data_out = force_zero ? 17'h0 : ({1'b0, ra} + {1'b0, rb} + 17'(bus.dp_carry_in));

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        sb_q.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.dp_clr_a !== 1'b1 || bus.dp_clr_b !== 1'b1) begin errors++; $display("FAIL reset_clr: got %b%b expected 11", bus.dp_clr_a, bus.dp_clr_b); end
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL reset_ready_busy: got %b%b expected 01", bus.in_ready, bus.busy); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 16'h0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_out: got v=%b s=%h e=%b expected 0 0000 0", bus.out_valid, bus.out_sum, bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.dp_clr_a !== 1'b1) begin errors++; $display("FAIL release_clr: got %b expected 1", bus.dp_clr_a); end
        @(posedge clk);
        #1;
        checks++; if (bus.dp_clr_a !== 1'b0 || bus.dp_clr_b !== 1'b0) begin errors++; $display("FAIL idle_clr: got %b%b expected 00", bus.dp_clr_a, bus.dp_clr_b); end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_state: got r=%b b=%b v=%b expected 1 0 0", bus.in_ready, bus.busy, bus.out_valid); end
    endtask

    task automatic test_basic();
        int cyc;
        logic [16:0] exp;
        send(16'h1234, 16'h4321, 1'b0);
        checks++; if (bus.dp_load_a !== 1'b1 || bus.dp_load_b !== 1'b0 || bus.dp_data_in !== 16'h1234) begin errors++; $display("FAIL load_a: got la=%b lb=%b d=%h expected 1 0 1234", bus.dp_load_a, bus.dp_load_b, bus.dp_data_in); end
        @(posedge clk);
        #1;
        checks++; if (bus.dp_load_b !== 1'b1 || bus.dp_load_a !== 1'b0 || bus.dp_data_in !== 16'h4321) begin errors++; $display("FAIL load_b: got la=%b lb=%b d=%h expected 0 1 4321", bus.dp_load_a, bus.dp_load_b, bus.dp_data_in); end
        @(posedge clk);
        #1;
        checks++; if (bus.dp_data_in !== 16'h0 || bus.busy !== 1'b1) begin errors++; $display("FAIL wait_bus: got d=%h busy=%b expected 0000 1", bus.dp_data_in, bus.busy); end
        wait_out(cyc);
        checks++; if (cyc + 2 !== 3) begin errors++; $display("FAIL latency: got %0d expected 3", cyc + 2); end
        exp = sb_q.pop_front();
        checks++; if ({bus.out_cout, bus.out_sum} !== exp || exp !== 17'h05555) begin errors++; $display("FAIL basic_sum: got %h expected %h", {bus.out_cout, bus.out_sum}, exp); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.dp_clr_a !== 1'b1 || bus.out_sum !== 16'h5555) begin errors++; $display("FAIL basic_clear: got v=%b clr=%b s=%h expected 0 1 5555", bus.out_valid, bus.dp_clr_a, bus.out_sum); end
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.dp_clr_a !== 1'b0) begin errors++; $display("FAIL basic_idle: got r=%b clr=%b expected 1 0", bus.in_ready, bus.dp_clr_a); end
    endtask

    task automatic test_carry();
        int cyc;
        logic [16:0] exp;
        logic [15:0] av[2] = '{16'hFFFF, 16'hFFFF};
        logic [15:0] bv[2] = '{16'h0001, 16'hFFFF};
        logic        cv[2] = '{1'b0, 1'b1};
        logic [16:0] rv[2] = '{17'h10000, 17'h1FFFF};
        for (int i = 0; i < 2; i++) begin
            bus.out_ready = 1'b1;
            send(av[i], bv[i], cv[i]);
            wait_out(cyc);
            exp = sb_q.pop_front();
            checks++; if ({bus.out_cout, bus.out_sum} !== exp || exp !== rv[i]) begin errors++; $display("FAIL carry_%0d: got %h expected %h", i, {bus.out_cout, bus.out_sum}, rv[i]); end
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.dp_clr_b !== 1'b1) begin errors++; $display("FAIL carry_hs_%0d: got v=%b clr=%b expected 0 1", i, bus.out_valid, bus.dp_clr_b); end
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [16:0] exp;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL stray_ready: got v=%b r=%b expected 0 1", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b0;
        send(16'h00AA, 16'h0055, 1'b1);
        wait_out(cyc);
        exp = sb_q.pop_front();
        checks++; if ({bus.out_cout, bus.out_sum} !== exp || exp !== 17'h00100) begin errors++; $display("FAIL bp_sum: got %h expected %h", {bus.out_cout, bus.out_sum}, exp); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.in_a     = 16'(i * 7);
            bus.in_b     = 16'hBEEF;
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.out_cout, bus.out_sum} !== exp) begin errors++; $display("FAIL bp_hold_%0d: got v=%b r=%b res=%h expected 1 0 %h", i, bus.out_valid, bus.in_ready, {bus.out_cout, bus.out_sum}, exp); end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.dp_clr_a !== 1'b1 || bus.out_sum !== 16'h0100) begin errors++; $display("FAIL bp_clear: got v=%b clr=%b s=%h expected 0 1 0100", bus.out_valid, bus.dp_clr_a, bus.out_sum); end
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || sb_q.size() !== 0) begin errors++; $display("FAIL bp_idle: got r=%b busy=%b q=%0d expected 1 0 0", bus.in_ready, bus.busy, sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [16:0] exp;
        send(16'h0001, 16'h0002, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0 || bus.dp_clr_a !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_%0d: got v=%b clr=%b r=%b expected 0 1 0", i, bus.out_valid, bus.dp_clr_a, bus.in_ready); end
        end
        rst_n = 1'b1;
        send(16'h0005, 16'h0003, 1'b1);
        wait_out(cyc);
        exp = sb_q.pop_front();
        checks++; if ({bus.out_cout, bus.out_sum} !== exp || exp !== 17'h00009) begin errors++; $display("FAIL mid_after: got %h expected %h", {bus.out_cout, bus.out_sum}, exp); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_err();
        int cyc;
        logic [16:0] exp;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b expected 0", bus.err); end
        force_zero = 1'b1;
        send(16'h0001, 16'h0001, 1'b0);
        void'(sb_q.pop_back());
        sb_q.push_back(17'h0);
        wait_out(cyc);
        exp = sb_q.pop_front();
        checks++; if ({bus.out_cout, bus.out_sum} !== exp) begin errors++; $display("FAIL err_forced: got %h expected %h", {bus.out_cout, bus.out_sum}, exp); end
        checks++; if (bus.err !== EXP_ERR) begin errors++; $display("FAIL err_set: got %b expected %b", bus.err, EXP_ERR); end
        force_zero = 1'b0;
        bus.out_ready = 1'b1;
        send(16'h0100, 16'h0200, 1'b0);
        wait_out(cyc);
        exp = sb_q.pop_front();
        checks++; if ({bus.out_cout, bus.out_sum} !== exp) begin errors++; $display("FAIL err_next: got %h expected %h", {bus.out_cout, bus.out_sum}, exp); end
        checks++; if (bus.err !== EXP_ERR) begin errors++; $display("FAIL err_sticky: got %b expected %b", bus.err, EXP_ERR); end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
